ks_sum_16b_pipe: RTL and testbench

KS_SUM_16B_PIPE -- requirements
Module: ks_sum_16b_pipe

---
 rtl/ks_sum_16b_pipe.sv | 126 ++++++++++++
 tb/tb_ks_sum_16b_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sum_16b_pipe.sv
// ============================================================================
// ks_sum_16b_pipe : Kogge-Stone sum stage with optional saturation and a
//                   2-entry registered output buffer (valid/ready on both sides).
// Revision 1.0
// ============================================================================
`default_nettype none

module ks_sum_16b_pipe #(
  parameter int SAT_EN = 0,
  parameter int DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_c0,
  input  logic [15:0] i_gk,
  input  logic [15:0] i_p_save,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_ovf,
  input  logic        i_ovf_clr,
  output logic        o_ovf_sticky
);

  localparam logic [1:0] C_FULL = DEPTH[1:0];

  // Entry layout: {ovf, cout, sum[15:0]}
  logic [15:0] w_carry;
  logic [15:0] w_sum_raw;
  logic [15:0] w_sum;
  logic        w_ovf;
  logic        w_cout;
  logic [17:0] w_entry;
  logic        w_push;
  logic        w_pop;

  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic [17:0] head_q, head_d;
  logic [17:0] tail_q, tail_d;
  logic        sticky_q, sticky_d;

  assign w_carry   = {i_gk[14:0], i_c0};
  assign w_sum_raw = i_p_save ^ w_carry;
  assign w_cout    = i_gk[15];
  assign w_ovf     = i_gk[15] ^ i_gk[14];

  generate
    if (SAT_EN != 0) begin : g_sat
      // Positive overflow has clear sign inputs and no carry out of bit 15.
      always_comb begin
        w_sum = w_sum_raw;
        if (w_ovf) begin
          w_sum = (!i_p_save[15] && !i_gk[15]) ? 16'h7FFF : 16'h8000;
        end
      end
    end else begin : g_nosat
      assign w_sum = w_sum_raw;
    end
  endgenerate

  assign w_entry = {w_ovf, w_cout, w_sum};
  assign w_push  = i_valid & ready_q;
  assign w_pop   = valid_q & i_ready;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
    sticky_d = sticky_q;

    if (w_push && w_pop) begin
      // Only reachable with one entry held: the new result becomes the head.
      head_d = w_entry;
    end else if (w_push) begin
      if (count_q == 2'd0) begin
        head_d = w_entry;
      end else begin
        tail_d = w_entry;
      end
    end else if (w_pop) begin
      head_d = tail_q;
    end

    valid_d = (count_d != 2'd0);
    ready_d = (count_d < C_FULL);

    if (w_push && w_ovf) begin
      sticky_d = 1'b1;
    end else if (i_ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      head_q   <= 18'd0;
      tail_q   <= 18'd0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_sum        = head_q[15:0];
  assign o_cout       = head_q[16];
  assign o_ovf        = head_q[17];
  assign o_ovf_sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_ks_sum_16b_pipe.sv
// ============================================================================
// tb_ks_sum_16b_pipe : self-checking bench for ks_sum_16b_pipe (SAT_EN 0 and 1).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ks_sum_16b_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, c0, ready, ovf_clr;
  logic [15:0] gk, p;

  logic        o_ready0, o_valid0, o_cout0, o_ovf0, o_sticky0;
  logic [15:0] o_sum0;
  logic        o_ready1, o_valid1, o_cout1, o_ovf1, o_sticky1;
  logic [15:0] o_sum1;

  always #5 clk = ~clk;

  ks_sum_16b_pipe #(.SAT_EN(0), .DEPTH(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready0),
    .i_c0(c0), .i_gk(gk), .i_p_save(p), .o_valid(o_valid0), .i_ready(ready),
    .o_sum(o_sum0), .o_cout(o_cout0), .o_ovf(o_ovf0),
    .i_ovf_clr(ovf_clr), .o_ovf_sticky(o_sticky0)
  );

  ks_sum_16b_pipe #(.SAT_EN(1), .DEPTH(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready1),
    .i_c0(c0), .i_gk(gk), .i_p_save(p), .o_valid(o_valid1), .i_ready(ready),
    .o_sum(o_sum1), .o_cout(o_cout1), .o_ovf(o_ovf1),
    .i_ovf_clr(ovf_clr), .o_ovf_sticky(o_sticky1)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [15:0] sat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Build prefix-tree style inputs (propagates and resolved carries) from operands.
  task automatic set_ab(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic c;
    c  = cin;
    c0 = cin;
    p  = a ^ b;
    for (int i = 0; i < 16; i++) begin
      c     = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      gk[i] = c;
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t        e;
    logic [16:0] s;
    s      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    e.sat  = e.ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : s[15:0];
    return e;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
    set_ab(a, b, cin);
    cur_exp = model(a, b, cin);
    valid   = 1'b1;
  endtask

  // Scoreboard work happens mid-cycle; the handshakes seen here fire at the next edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (o_valid0 && ready) begin
        n_pops++;
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum",      {16'd0, o_sum0}, {16'd0, e.sum});
          chk("cout",     {31'd0, o_cout0}, {31'd0, e.cout});
          chk("ovf",      {31'd0, o_ovf0}, {31'd0, e.ovf});
          chk("sat_sum",  {16'd0, o_sum1}, {16'd0, e.sat});
          chk("sat_ovf",  {31'd0, o_ovf1}, {31'd0, e.ovf});
        end
      end
      if (valid && o_ready0) q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h1234, 16'h0FF1, 1'b0, '{16'h2225, 1'b0, 1'b0, 16'h2225}};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 16'h7FFF}};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 16'h0000}};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 16'h8000}};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0, 16'h0001}};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 16'h8000}};
    tbl[6] = '{16'h4000, 16'h4000, 1'b0, '{16'h8000, 1'b0, 1'b1, 16'h7FFF}};
    tbl[7] = '{16'h5555, 16'hAAAA, 1'b1, '{16'h0000, 1'b1, 1'b0, 16'h0000}};

    rst = 1'b1; valid = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
    set_ab(16'h0, 16'h0, 1'b0);
    cur_exp = model(16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid",  {31'd0, o_valid0},  32'd0);
    chk("rst_ready",  {31'd0, o_ready0},  32'd1);
    chk("rst_sum",    {16'd0, o_sum0},    32'd0);
    chk("rst_cout",   {31'd0, o_cout0},   32'd0);
    chk("rst_ovf",    {31'd0, o_ovf0},    32'd0);
    chk("rst_sticky", {31'd0, o_sticky0}, 32'd0);

    // Single-cycle latency with the buffer empty
    drive(16'h1234, 16'h0FF1, 1'b0);
    tick();
    valid = 1'b0;
    chk("lat_valid", {31'd0, o_valid0}, 32'd1);
    chk("lat_sum",   {16'd0, o_sum0},   32'h2225);
    ready = 1'b1;
    tick();

    // Table vectors, back to back with a free-running sink
    for (int i = 0; i < 8; i++) begin
      set_ab(tbl[i].a, tbl[i].b, tbl[i].cin);
      cur_exp = tbl[i].e;
      valid   = 1'b1;
      tick();
    end
    valid = 1'b0;
    tick(); tick();
    chk("sticky_set", {31'd0, o_sticky0}, 32'd1);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr", {31'd0, o_sticky0}, 32'd0);

    // Clear together with an overflowing acceptance: set wins
    ovf_clr = 1'b1;
    drive(16'h7FFF, 16'h0001, 1'b0);
    tick();
    ovf_clr = 1'b0;
    valid   = 1'b0;
    chk("sticky_set_wins", {31'd0, o_sticky0}, 32'd1);
    tick(); tick();

    // Back-pressure: three offered, two held, third waits
    ready = 1'b0;
    drive(16'h0101, 16'h0202, 1'b0); tick();
    drive(16'h1111, 16'h2222, 1'b1); tick();
    drive(16'hA000, 16'h0ABC, 1'b0); tick(); tick(); tick();
    chk("full_ready", {31'd0, o_ready0}, 32'd0);
    chk("full_valid", {31'd0, o_valid0}, 32'd1);
    chk("hold_sum",   {16'd0, o_sum0},   32'h0303);
    chk("full_q",     q.size(),          32'd2);
    ready = 1'b1;
    tick(); tick();
    valid = 1'b0;
    tick(); tick();

    // Throughput from a full buffer
    ready = 1'b0;
    drive(16'h0F0F, 16'h00F0, 1'b0); tick(); tick();
    ready  = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end
    chk("throughput_pops", n_pops, 32'd10);
    valid = 1'b0;
    tick(); tick(); tick();

    // Reset with two entries buffered and sticky set
    ready = 1'b0;
    drive(16'h7000, 16'h7000, 1'b0); tick();
    drive(16'h9000, 16'h9000, 1'b0); tick();
    valid = 1'b0;
    chk("pre_rst_sticky", {31'd0, o_sticky0}, 32'd1);
    chk("pre_rst_ready",  {31'd0, o_ready0},  32'd0);
    rst = 1'b1; valid = 1'b1; ready = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b0; ready = 1'b0;
    q.delete();
    chk("mid_rst_valid",  {31'd0, o_valid0},  32'd0);
    chk("mid_rst_ready",  {31'd0, o_ready0},  32'd1);
    chk("mid_rst_sticky", {31'd0, o_sticky0}, 32'd0);
    chk("mid_rst_sticky1", {31'd0, o_sticky1}, 32'd0);

    drive(16'hFFFF, 16'hFFFF, 1'b1); tick();
    valid = 1'b0;
    ready = 1'b1;
    tick(); tick();
    chk("drain_valid", {31'd0, o_valid0}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
